// File: rtl/tfmbs_pkg.sv
// Shared control-plane definitions: result-bus geometry defaults and the drain FSM state encoding.
package tfmbs_pkg;

    localparam int unsigned DEFAULT_LANES = 15;
    localparam int unsigned DEFAULT_ACC_W = 32;

    // Index width able to address n items; never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEFAULT_LANE_IDX_W = idx_width(DEFAULT_LANES);

    localparam logic [1:0] DRAIN_IDLE_ENC   = 2'd0;
    localparam logic [1:0] DRAIN_STREAM_ENC = 2'd1;
    localparam logic [1:0] DRAIN_CLEAR_ENC  = 2'd2;

    typedef enum logic [1:0] {
        DRAIN_IDLE   = DRAIN_IDLE_ENC,
        DRAIN_STREAM = DRAIN_STREAM_ENC,
        DRAIN_CLEAR  = DRAIN_CLEAR_ENC
    } drain_state_e;

endpackage

// File: rtl/tfmbs_rise_detect.sv
// Registered rising-edge detector: rise_c is high in the cycle level goes 0->1 relative to
// the previous sample.
module tfmbs_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise_c
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise_c = level & ~level_q;

endmodule

// File: rtl/vector_result_drain.sv
// Snapshots the vector-engine accumulator bus on frame completion and streams it one lane per
// beat. Optional accumulator-clear phase after the last beat: define RESULT_DRAIN_CLEAR_EN.
module vector_result_drain
    import tfmbs_pkg::*;
#(
    parameter int unsigned LANES      = DEFAULT_LANES,
    parameter int unsigned ACC_W      = DEFAULT_ACC_W,
    parameter int unsigned LANE_IDX_W = DEFAULT_LANE_IDX_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_done,
    input  logic [LANES*ACC_W-1:0]  vector_results,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [ACC_W-1:0]        m_data,
    output logic [LANE_IDX_W-1:0]   m_lane,
    output logic                    m_last,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    clr_status
`ifdef RESULT_DRAIN_CLEAR_EN
    ,
    output logic                    acc_clear
`endif
);

    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

    drain_state_e             state;
    drain_state_e             state_nxt;
    logic [LANES*ACC_W-1:0]   shadow;
    logic [LANES*ACC_W-1:0]   shadow_nxt;
    logic [LANE_IDX_W-1:0]    lane_nxt;
    logic [ACC_W-1:0]         data_nxt;
    logic                     overrun_nxt;
    logic                     done_rise_c;
    logic                     xfer_c;

    tfmbs_rise_detect u_done_rise (
        .clk    (clk),
        .reset  (reset),
        .level  (frame_done),
        .rise_c (done_rise_c)
    );

    assign xfer_c = m_valid & m_ready;

    // m_lane doubles as the lane counter; the outputs are registered from the next-state values
    always_comb begin
        state_nxt   = state;
        shadow_nxt  = shadow;
        lane_nxt    = m_lane;
        overrun_nxt = overrun;
        data_nxt    = '0;

        case (state)
            DRAIN_IDLE: begin
                if (done_rise_c) begin
                    shadow_nxt = vector_results;
                    lane_nxt   = '0;
                    state_nxt  = DRAIN_STREAM;
                end
            end
            DRAIN_STREAM: begin
                if (xfer_c) begin
                    if (m_last) begin
                        lane_nxt = '0;
`ifdef RESULT_DRAIN_CLEAR_EN
                        state_nxt = DRAIN_CLEAR;
`else
                        state_nxt = DRAIN_IDLE;
`endif
                    end else begin
                        lane_nxt = m_lane + LANE_IDX_W'(1);
                    end
                end
            end
            DRAIN_CLEAR: begin
                state_nxt = DRAIN_IDLE;
            end
            default: begin
                state_nxt = DRAIN_IDLE;
                lane_nxt  = '0;
            end
        endcase

        // A coincident overrun event wins over the clear request
        if (clr_status) begin
            overrun_nxt = 1'b0;
        end
        if (done_rise_c && (state != DRAIN_IDLE)) begin
            overrun_nxt = 1'b1;
        end

        if (state_nxt == DRAIN_STREAM) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (lane_nxt == LANE_IDX_W'(k)) begin
                    data_nxt = shadow_nxt[k*ACC_W +: ACC_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= DRAIN_IDLE;
            shadow  <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_lane  <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
`ifdef RESULT_DRAIN_CLEAR_EN
            acc_clear <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            shadow  <= shadow_nxt;
            m_valid <= (state_nxt == DRAIN_STREAM);
            m_data  <= data_nxt;
            m_lane  <= lane_nxt;
            m_last  <= (state_nxt == DRAIN_STREAM) && (lane_nxt == LAST_LANE);
            busy    <= (state_nxt != DRAIN_IDLE);
            overrun <= overrun_nxt;
`ifdef RESULT_DRAIN_CLEAR_EN
            acc_clear <= (state_nxt == DRAIN_CLEAR);
`endif
        end
    end

endmodule

// File: tb/tb_vector_result_drain.sv
// Directed self-checking bench for vector_result_drain (15 lanes x 32 bits).
module tb_vector_result_drain;

    localparam int unsigned L  = 15;
    localparam int unsigned W  = 32;
    localparam int unsigned IW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_done;
    logic [L*W-1:0]   vr;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
    logic [IW-1:0]    m_lane;
    logic             m_last;
    logic             busy;
    logic             overrun;
    logic             clr_status;
`ifdef RESULT_DRAIN_CLEAR_EN
    logic             acc_clear;
`endif

    int checks = 0;
    int errors = 0;

    vector_result_drain dut (
        .clk            (clk),
        .reset          (reset),
        .frame_done     (frame_done),
        .vector_results (vr),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_lane         (m_lane),
        .m_last         (m_last),
        .busy           (busy),
        .overrun        (overrun),
        .clr_status     (clr_status)
`ifdef RESULT_DRAIN_CLEAR_EN
        ,
        .acc_clear      (acc_clear)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vr(input logic [W-1:0] base);
        for (int k = 0; k < int'(L); k++) vr[k*W +: W] = base + W'(k);
    endtask

    task automatic start_frame();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_done = 1'b0; m_ready = 1'b0; clr_status = 1'b0;
        vr = '0;
        tick(); tick();
        checks++;
        if ({m_valid, m_data, m_lane, m_last, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h lane=%0d last=%b busy=%b overrun=%b, required all 0",
                     m_valid, m_data, m_lane, m_last, busy, overrun);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b busy=%b, required 0 0", m_valid, busy);
        end
    endtask

    task automatic test_full_rate();
        load_vr(32'h1000_0000);
        m_ready = 1'b1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL full_rate_pre: valid=%b, required 0", m_valid);
        end
        start_frame();
        for (int b = 0; b < int'(L); b++) begin
            checks++;
            if (m_valid !== 1'b1 || m_lane !== IW'(b) || m_data !== 32'h1000_0000 + W'(b) ||
                m_last !== 1'(b == int'(L) - 1) || busy !== 1'b1) begin
                errors++;
                $display("FAIL full_rate beat %0d: valid=%b lane=%0d data=%h last=%b busy=%b, required 1 %0d %h %b 1",
                         b, m_valid, m_lane, m_data, m_last, busy, b, 32'h1000_0000 + W'(b), (b == int'(L) - 1));
            end
            tick();
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL full_rate_end_valid: valid=%b, required 0", m_valid);
        end
`ifdef RESULT_DRAIN_CLEAR_EN
        checks++;
        if (busy !== 1'b1 || acc_clear !== 1'b1) begin
            errors++; $display("FAIL clear_pulse: busy=%b acc_clear=%b, required 1 1", busy, acc_clear);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || acc_clear !== 1'b0) begin
            errors++; $display("FAIL clear_end: busy=%b acc_clear=%b, required 0 0", busy, acc_clear);
        end
`else
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL full_rate_busy_fall: busy=%b, required 0", busy);
        end
`endif
        idle_cycles(2);
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        int nxt;
        int cyc;
        pat = 4'b1001;
        nxt = 0;
        cyc = 0;
        load_vr(32'hC000_0100);
        m_ready = 1'b0;
        start_frame();
        while (nxt < int'(L) && cyc < 100) begin
            checks++;
            if (m_valid !== 1'b1 || m_lane !== IW'(nxt) || m_data !== 32'hC000_0100 + W'(nxt) ||
                m_last !== 1'(nxt == int'(L) - 1)) begin
                errors++;
                $display("FAIL stall cyc %0d: valid=%b lane=%0d data=%h last=%b, required 1 %0d %h %b",
                         cyc, m_valid, m_lane, m_data, m_last, nxt, 32'hC000_0100 + W'(nxt), (nxt == int'(L) - 1));
            end
            m_ready = pat[cyc % 4];
            if (m_ready) nxt++;
            cyc++;
            tick();
        end
        checks++;
        if (cyc >= 100) begin
            errors++; $display("FAIL stall_timeout: beats=%0d, required %0d", nxt, L);
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL stall_end: valid=%b, required 0", m_valid);
        end
        m_ready = 1'b1;
        idle_cycles(3);
    endtask

    task automatic test_hold_level();
        int beats;
        beats = 0;
        load_vr(32'h7000_0000);
        m_ready = 1'b1;
        frame_done = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c == 20) frame_done = 1'b0;
            tick();
            if (m_valid === 1'b1 && m_ready === 1'b1) beats++;
        end
        checks++;
        if (beats != int'(L) || overrun !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_level: beats=%0d overrun=%b valid=%b, required %0d 0 0", beats, overrun, m_valid, L);
        end
    endtask

    task automatic test_overrun();
        load_vr(32'h2000_0000);
        m_ready = 1'b1;
        start_frame();
        for (int b = 0; b < int'(L); b++) begin
            checks++;
            if (m_valid !== 1'b1 || m_lane !== IW'(b) || m_data !== 32'h2000_0000 + W'(b)) begin
                errors++;
                $display("FAIL overrun_drain beat %0d: valid=%b lane=%0d data=%h, required 1 %0d %h",
                         b, m_valid, m_lane, m_data, b, 32'h2000_0000 + W'(b));
            end
            if (b == 6) begin
                frame_done = 1'b0;
                checks++;
                if (overrun !== 1'b1) begin
                    errors++; $display("FAIL overrun_set: overrun=%b, required 1", overrun);
                end
            end
            if (b == 5) begin
                frame_done = 1'b1;
                load_vr(32'h3000_0000);
            end
            tick();
        end
        idle_cycles(3);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: valid=%b busy=%b overrun=%b, required 0 0 1", m_valid, busy, overrun);
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
        end
        start_frame();
        for (int b = 0; b < int'(L); b++) begin
            checks++;
            if (m_valid !== 1'b1 || m_lane !== IW'(b) || m_data !== 32'h3000_0000 + W'(b)) begin
                errors++;
                $display("FAIL fresh_drain beat %0d: valid=%b lane=%0d data=%h, required 1 %0d %h",
                         b, m_valid, m_lane, m_data, b, 32'h3000_0000 + W'(b));
            end
            if (b == 4) begin
                frame_done = 1'b0;
                clr_status = 1'b0;
                checks++;
                if (overrun !== 1'b1) begin
                    errors++; $display("FAIL clr_vs_event: overrun=%b, required 1", overrun);
                end
            end
            if (b == 3) begin
                frame_done = 1'b1;
                clr_status = 1'b1;
            end
            tick();
        end
        idle_cycles(3);
    endtask

    task automatic test_last_beat_overrun();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL last_beat_pre: overrun=%b, required 0", overrun);
        end
        load_vr(32'h8000_0000);
        m_ready = 1'b1;
        start_frame();
        for (int b = 0; b < int'(L); b++) begin
            if (b == int'(L) - 1) frame_done = 1'b1;
            tick();
        end
        checks++;
        if (overrun !== 1'b1 || m_valid !== 1'b0) begin
            errors++; $display("FAIL last_beat_overrun: overrun=%b valid=%b, required 1 0", overrun, m_valid);
        end
        idle_cycles(2);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL last_beat_no_restart: valid=%b busy=%b, required 0 0", m_valid, busy);
        end
        frame_done = 1'b0;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        tick();
    endtask

    task automatic test_snapshot_hold();
        load_vr(32'h4000_0000);
        m_ready = 1'b1;
        start_frame();
        for (int b = 0; b < int'(L); b++) begin
            checks++;
            if (m_valid !== 1'b1 || m_lane !== IW'(b) || m_data !== 32'h4000_0000 + W'(b)) begin
                errors++;
                $display("FAIL snapshot beat %0d: valid=%b lane=%0d data=%h, required 1 %0d %h",
                         b, m_valid, m_lane, m_data, b, 32'h4000_0000 + W'(b));
            end
            if (b == 4) vr = '1;
            tick();
        end
        idle_cycles(3);
    endtask

    task automatic test_reset_mid_stream();
        load_vr(32'h5000_0000);
        m_ready = 1'b1;
        start_frame();
        for (int b = 0; b < 7; b++) begin
            checks++;
            if (m_valid !== 1'b1 || m_lane !== IW'(b) || m_data !== 32'h5000_0000 + W'(b)) begin
                errors++;
                $display("FAIL pre_reset beat %0d: valid=%b lane=%0d data=%h, required 1 %0d %h",
                         b, m_valid, m_lane, m_data, b, 32'h5000_0000 + W'(b));
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_lane !== '0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b lane=%0d overrun=%b, required 0 0 0 0", m_valid, busy, m_lane, overrun);
        end
`ifdef RESULT_DRAIN_CLEAR_EN
        checks++;
        if (acc_clear !== 1'b0) begin
            errors++; $display("FAIL reset_mid_clear: acc_clear=%b, required 0", acc_clear);
        end
`endif
        tick();
        load_vr(32'h6000_0000);
        start_frame();
        for (int b = 0; b < int'(L); b++) begin
            checks++;
            if (m_valid !== 1'b1 || m_lane !== IW'(b) || m_data !== 32'h6000_0000 + W'(b)) begin
                errors++;
                $display("FAIL post_reset beat %0d: valid=%b lane=%0d data=%h, required 1 %0d %h",
                         b, m_valid, m_lane, m_data, b, 32'h6000_0000 + W'(b));
            end
            tick();
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_end: valid=%b, required 0", m_valid);
        end
        idle_cycles(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_rate();
        test_stall();
        test_hold_level();
        test_overrun();
        test_last_beat_overrun();
        test_snapshot_hold();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
